// File: rtl/shift_reg_sched_if.sv
// Bundle of the requester-side and serial-consumer-side signals of
// shift_reg_sched.
//   req       : per-requester request level
//   req_data  : requester i's word at [i*WIDTH +: WIDTH]
//   gnt       : one-hot grant pulse
//   ser_out   : current beat (top STEP bits of the shared register)
//   ser_valid : beat valid
//   ser_ready : consumer accepts beat
//   ser_last  : final beat of the word
//   ser_id    : requester owning the current word
//   busy      : word in progress
// master: the surrounding logic (requesters plus consumer).
// slave: the scheduler itself.
interface shift_reg_sched_if #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [STEP-1:0]       ser_out;
  logic                  ser_valid;
  logic                  ser_ready;
  logic                  ser_last;
  logic [IDW-1:0]        ser_id;
  logic                  busy;

  modport master (
    output req, req_data, ser_ready,
    input  gnt, ser_out, ser_valid, ser_last, ser_id, busy
  );

  modport slave (
    input  req, req_data, ser_ready,
    output gnt, ser_out, ser_valid, ser_last, ser_id, busy
  );
endinterface

// File: rtl/shift_reg_sched.sv
// Round-robin scheduler sharing one WIDTH-bit shift-register serializer
// among NREQ requesters. The granted word is loaded into the shared register
// and shifted out STEP bits per beat, MSB-first, under valid/ready.
// All registers update on the falling edge of clk. The reset is synchronous
// and active-high.
// Ports:
//   clk : clock (negative-edge datapath)
//   rst : synchronous active-high reset
//   bus : shift_reg_sched_if.slave (req/req_data/gnt and the ser_* stream)
module shift_reg_sched #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8,
  parameter int NREQ  = 4
) (
  input  logic             clk,
  input  logic             rst,
  shift_reg_sched_if.slave bus
);
  localparam int BEATS = WIDTH / STEP;
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [IDW:0]  NREQ_W    = (IDW + 1)'(NREQ);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sreg_reg, sreg_next;
  logic [BW-1:0]    beat_reg, beat_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [IDW-1:0]   id_reg, id_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;

  // Arbitration: rotate req so that bit 0 is the requester at ptr, find the
  // lowest set bit of the rotated vector, then add ptr back (mod NREQ).
  logic [NREQ-1:0]           req_rot;
  logic [NREQ-1:0]           pick;
  logic [NREQ:0][IDW-1:0]    off_acc;
  logic [IDW:0]              win_sum;
  logic [IDW-1:0]            win;
  logic [IDW-1:0]            win_inc;
  logic                      any_req;
  logic                      last_beat;
  logic [WIDTH-1:0]          word_arr [NREQ];

  assign off_acc[0] = '0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [NREQ-1:0] hit;
    for (genvar pj = 0; pj < NREQ; pj++) begin : g_rot
      assign hit[pj] = (ptr_reg == IDW'(pj)) & bus.req[(pj + gi) % NREQ];
    end
    assign req_rot[gi] = |hit;

    if (gi == 0) begin : g_first
      assign pick[gi] = req_rot[gi];
    end else begin : g_rest
      assign pick[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
    end

    // pick is one-hot (or zero), so OR-ing the offsets selects the winner.
    assign off_acc[gi+1] = off_acc[gi] | (pick[gi] ? IDW'(gi) : '0);
    assign word_arr[gi]  = bus.req_data[gi*WIDTH +: WIDTH];
  end

  assign any_req   = |bus.req;
  assign win_sum   = {1'b0, ptr_reg} + {1'b0, off_acc[NREQ]};
  assign win       = (win_sum >= NREQ_W) ? IDW'(win_sum - NREQ_W) : win_sum[IDW-1:0];
  assign win_inc   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
  assign last_beat = (beat_reg == LAST_BEAT);

  // State register
  always_ff @(negedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sreg_reg  <= '0;
      beat_reg  <= '0;
      ptr_reg   <= '0;
      id_reg    <= '0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sreg_reg  <= sreg_next;
      beat_reg  <= beat_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      gnt_reg   <= gnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    sreg_next  = sreg_reg;
    beat_next  = beat_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    gnt_next   = '0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = SHIFT;
          sreg_next  = word_arr[win];
          beat_next  = '0;
          ptr_next   = win_inc;
          id_next    = win;
          gnt_next   = NREQ'(1) << win;
        end
      end
      SHIFT: begin
        if (bus.ser_ready) begin
          if (last_beat) begin
            // Clearing sreg and id keeps ser_out/ser_id at zero while idle.
            state_next = IDLE;
            sreg_next  = '0;
            beat_next  = '0;
            id_next    = '0;
          end else begin
            sreg_next = sreg_reg << STEP;
            beat_next = beat_reg + BW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: every output is a function of registered state only.
  always_comb begin
    bus.gnt       = gnt_reg;
    bus.ser_out   = sreg_reg[WIDTH-1 -: STEP];
    bus.ser_valid = (state_reg == SHIFT);
    bus.busy      = (state_reg == SHIFT);
    bus.ser_last  = (state_reg == SHIFT) && last_beat;
    bus.ser_id    = id_reg;
  end
endmodule

// File: doc/shift_reg_sched.md
# shift_reg_sched

Round-robin scheduler that shares one WIDTH-bit shift-register serializer among NREQ requesters. A granted requester's parallel word is loaded into the shared register and shifted out STEP bits per beat, MSB-first, under a valid/ready handshake. The block sits between the requesting datapath blocks and the downstream serial consumer. All state updates on the falling edge of clk, matching the rest of the negative-edge datapath.

## Interface
Parameters:
- WIDTH, 32, word width; must be a multiple of STEP
- STEP, 8, bits emitted per beat; BEATS = WIDTH/STEP
- NREQ, 4, number of requesters (2..8)

Ports:
- clk  in  1  clock; all registers update on negedge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request, level
- req_data  in  NREQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, one-cycle pulse
- ser_out  out  STEP  current beat, top STEP bits of shift register
- ser_valid  out  1  beat valid
- ser_ready  in  1  consumer accepts beat
- ser_last  out  1  final beat of word
- ser_id  out  clog2(NREQ)  index of the requester owning the current word
- busy  out  1  word in progress

## Operation
- States: IDLE, SHIFT. Internal: sreg[WIDTH], beat counter, rr pointer ptr (clog2(NREQ) bits).
- IDLE, req != 0 at an edge: the winner is the first set req[i] scanning ptr, ptr+1, ... with wrap. Same edge: sreg <= winner's req_data, gnt <= onehot(winner), ser_id <= winner, beat <= 0, ptr <= winner+1 mod NREQ, state <= SHIFT.
- IDLE, req == 0: all outputs stay 0.
- SHIFT: ser_valid=1, busy=1, ser_out=sreg[WIDTH-1 -: STEP], ser_last=(beat==BEATS-1).
- SHIFT edge with ser_ready=1, not last: sreg <= sreg << STEP, beat++.
- SHIFT edge with ser_ready=1, last: state <= IDLE, ser_valid/busy/ser_last drop, sreg cleared.
- SHIFT edge with ser_ready=0: all state held. ser_out, ser_last, and ser_id remain stable.
- req is ignored in SHIFT. A requester may withdraw req before it is granted. A requester must drop req on the edge after it sees gnt, otherwise it is treated as a new request.
- req_data is sampled only on the granting edge.

## Timing
- Reset values: gnt=0, ser_out=0, ser_valid=0, ser_last=0, ser_id=0, busy=0, ptr=0, state IDLE. Requester 0 has highest priority after reset.
- rst during SHIFT aborts the word. Next cycle all outputs are at reset values, and no further beat of that word is emitted.
- rst has priority over any simultaneous req or ser_ready.
- Grant latency: req sampled high at IDLE edge k -> gnt and first beat (ser_valid=1) both visible in cycle k+1. gnt falls at edge k+1.
- With ser_ready held 1: BEATS SHIFT cycles, then one mandatory IDLE cycle. Throughput is one word per BEATS+1 cycles.
- ser_last is high exactly in the cycle of the final beat.
- All outputs are registered; there is no combinational path from req or ser_ready to any output.

## Test plan
WIDTH=32, STEP=8, NREQ=4, ser_ready=1 unless stated.
- **Single request:** req=0001, data0=0xA1B2C3D4.
  - gnt=0001 for one cycle.
  - ser_out A1,B2,C3,D4 on 4 consecutive cycles, with ser_last only on D4.
  - ser_id=0 and busy=1 for 4 cycles, then idle.
- **All requesters held:** req=1111 held, each dropped after its grant then reasserted.
  - Grant order 0,1,2,3,0.
  - Grants exactly 5 cycles apart.
- **Round-robin pointer:** after a grant to requester 2, req=1001.
  - Requester 3 is granted before requester 0.
- **Backpressure:** ser_ready low for 3 cycles while ser_out=B2.
  - ser_out=B2, ser_valid=1, ser_last=0 held for 4 cycles, then C3, D4.
- **Reset mid-word:** rst pulsed after beat A1 accepted.
  - Next cycle all outputs 0, and B2 is never emitted.
  - With req=1010 then pending, requester 1 is granted first (ptr reset to 0).
- **Withdrawal:** req[2] raised and dropped entirely within another word's SHIFT period.
  - gnt[2] never asserts.
